// File: rtl/clock_pkg.sv
// Shared types and constants for the wall-clock set controller.
package clock_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2
  } mode_e;

  localparam int unsigned HOURS_PER_DAY = 24;
  localparam int unsigned MIN_PER_HOUR  = 60;
  localparam int unsigned HOUR_W        = 5;
  localparam int unsigned MIN_W         = 6;

  // Hour increment with wrap 23 -> 0.
  function automatic logic [HOUR_W-1:0] next_hour(input logic [HOUR_W-1:0] h);
    return (h == HOUR_W'(HOURS_PER_DAY - 1)) ? '0 : h + 1'b1;
  endfunction

  // Minute increment with wrap 59 -> 0.
  function automatic logic [MIN_W-1:0] next_min(input logic [MIN_W-1:0] m);
    return (m == MIN_W'(MIN_PER_HOUR - 1)) ? '0 : m + 1'b1;
  endfunction

endpackage

// File: rtl/clock_set_ctrl_if.sv
// Button, time-counter and display signals of the set controller.
// master: the controller; slave: the board / counter / display side.
interface clock_set_ctrl_if;
  import clock_pkg::*;

  logic              btn_mode;
  logic              btn_inc;
  logic [HOUR_W-1:0] cur_hour;
  logic [MIN_W-1:0]  cur_min;
  logic              sec_tick;
  logic              load;
  logic [HOUR_W-1:0] load_hour;
  logic [MIN_W-1:0]  load_min;
  logic [HOUR_W-1:0] disp_hour;
  logic [MIN_W-1:0]  disp_min;
  logic [3:0]        blank_mask;
  logic [1:0]        mode;

  modport master (
    input  btn_mode, btn_inc, cur_hour, cur_min,
    output sec_tick, load, load_hour, load_min, disp_hour, disp_min,
           blank_mask, mode
  );

  modport slave (
    output btn_mode, btn_inc, cur_hour, cur_min,
    input  sec_tick, load, load_hour, load_min, disp_hour, disp_min,
           blank_mask, mode
  );

endinterface

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stable-level debouncer
// and a one-cycle pulse on each accepted press (release is silent).
module btn_debounce #(
  parameter int unsigned DEB_CYC = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press
);

  localparam int unsigned CNT_W = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;

  logic             sync1;
  logic             sync2;
  logic             level;
  logic             level_d;
  logic [CNT_W-1:0] cnt;

  // Bring the asynchronous button into the clock domain.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
    end
  end

  // Accept a new level only after it has differed for DEB_CYC straight cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      level <= 1'b0;
      cnt   <= '0;
    end else if (sync2 == level) begin
      cnt <= '0;
    end else if (cnt == CNT_W'(DEB_CYC - 1)) begin
      level <= sync2;
      cnt   <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Registered rising-edge detect of the debounced level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      level_d <= 1'b0;
      press   <= 1'b0;
    end else begin
      level_d <= level;
      press   <= level & ~level_d;
    end
  end

endmodule

// File: rtl/clock_set_ctrl.sv
// Wall-clock controller: 1 Hz prescaler, RUN/SET_HOUR/SET_MIN mode machine,
// edit registers with load-back on exit, and blinking of the edited digits.
module clock_set_ctrl
  import clock_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 12000000,
  parameter int unsigned DEBOUNCE_MS = 20,
  parameter int unsigned BLINK_HZ    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  clock_set_ctrl_if.master bus
);

  localparam int unsigned DEB_CYC    = CLK_HZ / 1000 * DEBOUNCE_MS;
  localparam int unsigned HALF_BLINK = CLK_HZ / (2 * BLINK_HZ);
  localparam int unsigned PS_W       = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int unsigned BL_W       = (HALF_BLINK > 1) ? $clog2(HALF_BLINK) : 1;

  logic              mode_press;
  logic              inc_press;

  mode_e             state;
  mode_e             state_nxt;
  logic [HOUR_W-1:0] e_hour;
  logic [HOUR_W-1:0] e_hour_nxt;
  logic [MIN_W-1:0]  e_min;
  logic [MIN_W-1:0]  e_min_nxt;
  logic              load_nxt;

  logic [PS_W-1:0]   ps_cnt;
  logic [BL_W-1:0]   blink_cnt;
  logic [BL_W-1:0]   blink_cnt_nxt;
  logic              blink_ph;
  logic              blink_ph_nxt;
  logic [3:0]        blank_nxt;

  logic              sec_tick_q;
  logic              load_q;
  logic [HOUR_W-1:0] disp_hour_q;
  logic [MIN_W-1:0]  disp_min_q;
  logic [3:0]        blank_q;

  btn_debounce #(.DEB_CYC(DEB_CYC)) u_mode_btn (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (bus.btn_mode),
    .press (mode_press)
  );

  btn_debounce #(.DEB_CYC(DEB_CYC)) u_inc_btn (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (bus.btn_inc),
    .press (inc_press)
  );

  // Mode transitions and edit-register updates; a mode press masks inc.
  always_comb begin
    state_nxt  = state;
    e_hour_nxt = e_hour;
    e_min_nxt  = e_min;
    load_nxt   = 1'b0;
    case (state)
      RUN: begin
        if (mode_press) begin
          state_nxt  = SET_HOUR;
          e_hour_nxt = bus.cur_hour;
          e_min_nxt  = bus.cur_min;
        end
      end
      SET_HOUR: begin
        if (mode_press)     state_nxt  = SET_MIN;
        else if (inc_press) e_hour_nxt = next_hour(e_hour);
      end
      SET_MIN: begin
        if (mode_press) begin
          state_nxt = RUN;
          load_nxt  = 1'b1;
        end else if (inc_press) begin
          e_min_nxt = next_min(e_min);
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  // Blink phase restarts visible on every state change and idles in RUN.
  always_comb begin
    blink_cnt_nxt = '0;
    blink_ph_nxt  = 1'b0;
    if (state_nxt == state && state != RUN) begin
      if (blink_cnt == BL_W'(HALF_BLINK - 1)) begin
        blink_cnt_nxt = '0;
        blink_ph_nxt  = ~blink_ph;
      end else begin
        blink_cnt_nxt = blink_cnt + 1'b1;
        blink_ph_nxt  = blink_ph;
      end
    end
    blank_nxt = '0;
    if (blink_ph_nxt) begin
      case (state_nxt)
        SET_HOUR: blank_nxt = 4'b0011;
        SET_MIN:  blank_nxt = 4'b1100;
        default:  blank_nxt = '0;
      endcase
    end
  end

  // Seconds prescaler: free-runs in RUN, held at zero while editing.
  always_ff @(posedge clk) begin
    if (!rst_n || state != RUN) begin
      ps_cnt <= '0;
    end else if (ps_cnt == PS_W'(CLK_HZ - 1)) begin
      ps_cnt <= '0;
    end else begin
      ps_cnt <= ps_cnt + 1'b1;
    end
  end

  // Blink counter and phase registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      blink_cnt <= '0;
      blink_ph  <= 1'b0;
    end else begin
      blink_cnt <= blink_cnt_nxt;
      blink_ph  <= blink_ph_nxt;
    end
  end

  // State, edit registers and registered outputs. Outputs are built from the
  // next-state values so they line up with the cycle in which mode changes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= RUN;
      e_hour      <= '0;
      e_min       <= '0;
      sec_tick_q  <= 1'b0;
      load_q      <= 1'b0;
      disp_hour_q <= bus.cur_hour;
      disp_min_q  <= bus.cur_min;
      blank_q     <= '0;
    end else begin
      state       <= state_nxt;
      e_hour      <= e_hour_nxt;
      e_min       <= e_min_nxt;
      sec_tick_q  <= (state == RUN) && (state_nxt == RUN) &&
                     (ps_cnt == PS_W'(CLK_HZ - 1));
      load_q      <= load_nxt;
      disp_hour_q <= (state_nxt == RUN) ? bus.cur_hour : e_hour_nxt;
      disp_min_q  <= (state_nxt == RUN) ? bus.cur_min  : e_min_nxt;
      blank_q     <= blank_nxt;
    end
  end

  assign bus.sec_tick   = sec_tick_q;
  assign bus.load       = load_q;
  assign bus.load_hour  = e_hour;
  assign bus.load_min   = e_min;
  assign bus.disp_hour  = disp_hour_q;
  assign bus.disp_min   = disp_min_q;
  assign bus.blank_mask = blank_q;
  assign bus.mode       = state;

endmodule
